unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: the IF stage (fetch, read-only) and the MEM stage (load/store).
- Sequences each access through a fixed-latency memory.
- Drives the pipeline-wide stop into the hazard unit while any request is outstanding.
- Gives the MEM stage priority, with an anti-starvation rule so fetch always progresses.

Parameters:
AW, 16, address width
DW, 16, data width
MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (legal 1..15)

Ports:
clk  in  1  clock; all flops rise-edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held high until if_ack
if_addr  in  AW  fetch address
if_rdata  out  DW  fetched instruction; valid while if_ack=1
if_ack  out  1  one-cycle fetch completion pulse
dm_req  in  1  data request; held high until dm_ack
dm_we  in  1  1=store, 0=load
dm_addr  in  AW  data address
dm_wdata  in  DW  store data
dm_rdata  out  DW  load data; valid while dm_ack=1
dm_ack  out  1  one-cycle data completion pulse
mem_en  out  1  memory access strobe, one cycle per access
mem_we  out  1  memory write enable (qualified by mem_en)
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid in cycle ISSUE+MEM_LAT
stop  out  1  pipeline freeze to hazard unit
owner  out  1  current/last grant: 0=fetch, 1=data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, wait counter=0, starve=0.
  - All registered outputs are 0: if_ack, dm_ack, if_rdata, dm_rdata, mem_en, mem_we, mem_addr, mem_wdata, owner.
  - An in-flight access is abandoned and no ack is issued. A store already strobed may have completed in memory.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Samples requests each edge.
  - Grant: if starve=1 and if_req, grant fetch. Otherwise dm_req wins over if_req.
  - On grant, latch addr/we/wdata (fetch forces we=0), set owner, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - Exactly one cycle.
  - mem_en=1, mem_we/mem_addr/mem_wdata come from the latched values.
  - Counter loads MEM_LAT. Go to WAIT.
- WAIT:
  - mem_en=0. Counter decrements each cycle.
  - At the edge where counter==1, capture mem_rdata into the granted side's rdata register and go to DONE.
  - WAIT therefore lasts exactly MEM_LAT cycles.
  - Stores also pass through WAIT; rdata registers are unchanged on stores.
- DONE:
  - Exactly one cycle; pulses the granted side's ack.
  - The acked requester's req is masked this cycle (it drops in the next cycle).
  - The other requester is sampled exactly as in IDLE, so back-to-back ISSUE is possible with no idle gap. Otherwise go to IDLE.
- Latency: request seen in IDLE at cycle R gives mem_en at R+1 and ack at R+MEM_LAT+2.
- starve flag:
  - Set when fetch and data both request and data is granted.
  - Cleared when fetch is granted.
  - Guarantees fetch at most one data access of wait under contention.
- stop = (if_req & ~if_ack) | (dm_req & ~dm_ack), combinational.
  - Low in the ack cycle, so the pipeline advances in lock-step with the ack.
- Requesters may change addr/data after grant, since values are latched at grant. A req dropped before grant issues nothing.
- Deasserting req after grant but before ack is a protocol violation; the access still completes and acks.
- MEM_LAT=1: WAIT lasts one cycle. Counter is 4 bits and never wraps.

Test Plan:
- MEM_LAT=2, reset released, if_req=1 with if_addr=0x0010 at cycle 0, memory returns 0xA5A5 → mem_en=1 with mem_addr=0x0010 in cycle 1; if_ack=1 with if_rdata=0xA5A5 in cycle 4; stop=1 in cycles 0–3 and 0 in cycle 4.
- dm_req store (dm_we=1, addr 0x0200, wdata 0x1234) → mem_en=mem_we=1 with addr 0x0200 and wdata 0x1234 in cycle 1; dm_ack in cycle 4; dm_rdata unchanged.
- if_req and dm_req both high at cycle 0 → data is granted first (owner=1), starve=1; DONE at cycle 4; fetch ISSUE at cycle 5; if_ack at cycle 8.
- Both held continuously for 4 transactions → grants alternate D, I, D, I; never two data grants between fetch grants.
- rst pulled low during WAIT → all outputs 0 immediately and no ack. After release, a new if_req completes with normal R+4 timing.
- MEM_LAT=1 sweep and back-to-back requests from the DONE cycle → ack at R+3 and the next mem_en in the cycle after DONE.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory buses of the shared
// instruction/data memory arbiter.
interface unified_mem_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      input  mem_rdata,
      output if_rdata, if_ack,
      output dm_rdata, dm_ack,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr,
      output dm_req, dm_we, dm_addr, dm_wdata,
      output mem_rdata,
      input  if_rdata, if_ack,
      input  dm_rdata, dm_ack,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates IF fetch and MEM load/store onto one
// fixed-latency single-port memory; data wins, fetch never starves.
module unified_mem_arbiter #(
   parameter int AW      = 16,
   parameter int DW      = 16,
   parameter int MEM_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   unified_mem_arbiter_if.slave bus,
   output logic                 stop,
   output logic                 owner
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   logic [1:0]    state;
   logic [3:0]    cnt;
   logic          starve;
   logic          open_q;
   logic          if_v;
   logic          dm_v;
   logic          gnt_if;
   logic          gnt_dm;
   logic [AW-1:0] nxt_addr;
   logic [DW-1:0] nxt_wdata;

   // In DONE the side being acked is masked; its req drops next cycle.
   always_comb begin
      open_q    = (state == IDLE) | (state == DONE);
      if_v      = bus.if_req & ~((state == DONE) & ~owner);
      dm_v      = bus.dm_req & ~((state == DONE) & owner);
      gnt_if    = open_q & if_v & (starve | ~dm_v);
      gnt_dm    = open_q & dm_v & ~gnt_if;
      nxt_addr  = gnt_dm ? bus.dm_addr : bus.if_addr;
      nxt_wdata = gnt_dm ? bus.dm_wdata : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         cnt           <= '0;
         starve        <= 1'b0;
         owner         <= 1'b0;
         bus.if_ack    <= 1'b0;
         bus.dm_ack    <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.mem_en    <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         bus.if_ack <= 1'b0;
         bus.dm_ack <= 1'b0;
         bus.mem_en <= 1'b0;
         unique case (state)
            IDLE, DONE: begin
               if (gnt_if | gnt_dm) begin
                  state         <= ISSUE;
                  owner         <= gnt_dm;
                  bus.mem_en    <= 1'b1;
                  bus.mem_we    <= gnt_dm & bus.dm_we;
                  bus.mem_addr  <= nxt_addr;
                  bus.mem_wdata <= nxt_wdata;
                  if (gnt_if)
                     starve <= 1'b0;
                  else if (if_v)
                     starve <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            ISSUE: begin
               cnt   <= LAT;
               state <= WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= DONE;
                  if (owner) begin
                     bus.dm_ack <= 1'b1;
                     if (!bus.mem_we)
                        bus.dm_rdata <= bus.mem_rdata;
                  end else begin
                     bus.if_ack   <= 1'b1;
                     bus.if_rdata <= bus.mem_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign stop = (bus.if_req & ~bus.if_ack)
               | (bus.dm_req & ~bus.dm_ack);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter at MEM_LAT=2 (lane 0)
// and MEM_LAT=1 (lane 1).
module tb_unified_mem_arbiter;
   typedef struct {
      bit          side;
      bit          we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          iss;
      int          ack;
   } acc_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]  rst = 2'b00;
   logic [1:0]  if_req = 2'b00;
   logic [1:0]  dm_req = 2'b00;
   logic [1:0]  dm_we = 2'b00;
   logic [15:0] if_addr [2];
   logic [15:0] dm_addr [2];
   logic [15:0] dm_wdata [2];
   logic [1:0]  if_ack, dm_ack, mem_en, mem_we, stop, owner;
   logic [15:0] if_rdata [2];
   logic [15:0] dm_rdata [2];
   logic [15:0] mem_addr [2];
   logic [15:0] mem_wdata [2];

   acc_t        iq [2][$];
   acc_t        aq [2][$];
   logic [15:0] last_dm [2];
   int          n_ack [2];
   int          n_chk = 0;
   int          n_pass = 0;

   function automatic logic [15:0] fmem(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h3C3C) + 16'h0101;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t",
                    tag, got, exp, $time);
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_lane
      localparam int LAT = (g == 0) ? 2 : 1;

      unified_mem_arbiter_if #(.AW(16), .DW(16)) bus ();

      assign bus.if_req   = if_req[g];
      assign bus.if_addr  = if_addr[g];
      assign bus.dm_req   = dm_req[g];
      assign bus.dm_we    = dm_we[g];
      assign bus.dm_addr  = dm_addr[g];
      assign bus.dm_wdata = dm_wdata[g];
      assign if_ack[g]    = bus.if_ack;
      assign dm_ack[g]    = bus.dm_ack;
      assign if_rdata[g]  = bus.if_rdata;
      assign dm_rdata[g]  = bus.dm_rdata;
      assign mem_en[g]    = bus.mem_en;
      assign mem_we[g]    = bus.mem_we;
      assign mem_addr[g]  = bus.mem_addr;
      assign mem_wdata[g] = bus.mem_wdata;

      unified_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(LAT)) u_dut (
         .clk   (clk),
         .rst   (rst[g]),
         .bus   (bus),
         .stop  (stop[g]),
         .owner (owner[g])
      );

      // Memory model: read data valid only in cycle ISSUE+LAT.
      bit   [1023:0] wr_v;
      logic [15:0]   wr_d [1024];
      logic [15:0]   rd_q;
      int            age;

      always @(posedge clk) begin
         if (bus.mem_en) begin
            age <= 1;
            if (bus.mem_we) begin
               wr_v[bus.mem_addr[9:0]] <= 1'b1;
               wr_d[bus.mem_addr[9:0]] <= bus.mem_wdata;
               rd_q <= 16'hDEAD;
            end else begin
               rd_q <= wr_v[bus.mem_addr[9:0]] ? wr_d[bus.mem_addr[9:0]]
                                                : fmem(bus.mem_addr);
            end
         end else if (age != 0 && age < 99) begin
            age <= age + 1;
         end
      end

      assign bus.mem_rdata = (age == LAT) ? rd_q : 16'hDEAD;
   end

   always @(negedge clk) begin
      acc_t e;
      for (int l = 0; l < 2; l++) begin
         if (rst[l]) begin
            if (mem_en[l]) begin
               if (iq[l].size() == 0) begin
                  chk("en_unexp", 32'(mem_en[l]), 32'(0));
               end else begin
                  e = iq[l].pop_front();
                  chk("iss_cyc", 32'(cyc), 32'(e.iss));
                  chk("iss_we", 32'(mem_we[l]), 32'(e.we));
                  chk("iss_addr", 32'(mem_addr[l]), 32'(e.addr));
                  if (e.we) chk("iss_wdata", 32'(mem_wdata[l]), 32'(e.wdata));
               end
            end
            if (if_ack[l] | dm_ack[l]) begin
               n_ack[l]++;
               chk("ack_one", 32'(if_ack[l] & dm_ack[l]), 32'(0));
               if (aq[l].size() == 0) begin
                  chk("ack_unexp", 32'({if_ack[l], dm_ack[l]}), 32'(0));
               end else begin
                  e = aq[l].pop_front();
                  chk("ack_side", 32'(dm_ack[l]), 32'(e.side));
                  chk("ack_cyc", 32'(cyc), 32'(e.ack));
                  chk("ack_data", 32'(e.side ? dm_rdata[l] : if_rdata[l]),
                      32'(e.rdata));
                  chk("owner", 32'(owner[l]), 32'(e.side));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int l, input bit side, input bit we,
                       input logic [15:0] ad, input logic [15:0] wd,
                       input logic [15:0] rd, input int iss, input int ack,
                       input bit acked);
      acc_t a;
      a.side  = side;
      a.we    = we;
      a.addr  = ad;
      a.wdata = wd;
      a.rdata = rd;
      a.iss   = iss;
      a.ack   = ack;
      iq[l].push_back(a);
      if (acked) aq[l].push_back(a);
   endtask

   task automatic fetch(input int l, input logic [15:0] a);
      int n = 0;
      if_addr[l] = a;
      if_req[l]  = 1'b1;
      @(negedge clk);
      while (!if_ack[l] && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!if_ack[l]) chk("if_tmo", 32'(if_ack[l]), 32'(1));
      @(posedge clk);
      #1;
      if_req[l]  = 1'b0;
      if_addr[l] = 16'hFFFF;
   endtask

   task automatic data(input int l, input bit we, input logic [15:0] a,
                       input logic [15:0] wd);
      int n = 0;
      dm_we[l]    = we;
      dm_addr[l]  = a;
      dm_wdata[l] = wd;
      dm_req[l]   = 1'b1;
      @(negedge clk);
      while (!dm_ack[l] && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!dm_ack[l]) chk("dm_tmo", 32'(dm_ack[l]), 32'(1));
      @(posedge clk);
      #1;
      dm_req[l]   = 1'b0;
      dm_addr[l]  = 16'hFFFF;
      dm_wdata[l] = 16'hFFFF;
   endtask

   task automatic rst_checks(input int l);
      chk("rst_if_ack", 32'(if_ack[l]), 32'(0));
      chk("rst_dm_ack", 32'(dm_ack[l]), 32'(0));
      chk("rst_if_rdata", 32'(if_rdata[l]), 32'(0));
      chk("rst_dm_rdata", 32'(dm_rdata[l]), 32'(0));
      chk("rst_mem_en", 32'(mem_en[l]), 32'(0));
      chk("rst_mem_we", 32'(mem_we[l]), 32'(0));
      chk("rst_mem_addr", 32'(mem_addr[l]), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata[l]), 32'(0));
      chk("rst_owner", 32'(owner[l]), 32'(0));
   endtask

   task automatic drain(input int l);
      int n = 0;
      while ((iq[l].size() != 0 || aq[l].size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain", 32'(iq[l].size() + aq[l].size()), 32'(0));
   endtask

   initial begin
      int R;
      int L;
      int nb;
      logic [15:0] fa [4];
      for (int l = 0; l < 2; l++) begin
         if_addr[l]  = '0;
         dm_addr[l]  = '0;
         dm_wdata[l] = '0;
         last_dm[l]  = '0;
         n_ack[l]    = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
         rst_checks(l);
         chk("rst_stop", 32'(stop[l]), 32'(0));
      end
      rst = 2'b11;
      step();

      for (int l = 0; l < 2; l++) begin
         L = (l == 0) ? 2 : 1;

         // Single fetch, with stop profile across the access.
         R = cyc;
         push(l, 0, 0, 16'h0010, 16'h0, 16'hA5A5, R + 1, R + L + 2, 1);
         fork
            fetch(l, 16'h0010);
            begin
               for (int k = 0; k <= L + 2; k++) begin
                  @(negedge clk);
                  chk("stop", 32'(stop[l]), 32'(k != L + 2));
               end
            end
         join

         // Store leaves dm_rdata alone; a load reads it back.
         R = cyc;
         push(l, 1, 1, 16'h0200, 16'h1234, last_dm[l], R + 1, R + L + 2, 1);
         data(l, 1'b1, 16'h0200, 16'h1234);
         R = cyc;
         push(l, 1, 0, 16'h0200, 16'h0, 16'h1234, R + 1, R + L + 2, 1);
         last_dm[l] = 16'h1234;
         data(l, 1'b0, 16'h0200, 16'h5555);

         // Both held: D, I, D, I back to back from each DONE.
         R = cyc;
         fa[0] = 16'h0300;
         fa[1] = 16'h0020;
         fa[2] = 16'h0304;
         fa[3] = 16'h0022;
         push(l, 1, 0, fa[0], 16'h0, fmem(fa[0]), R + 1, R + (L + 2), 1);
         last_dm[l] = fmem(fa[0]);
         push(l, 0, 0, fa[1], 16'h0, fmem(fa[1]),
              R + 1 + (L + 2), R + 2 * (L + 2), 1);
         push(l, 1, 1, fa[2], 16'hBEEF, last_dm[l],
              R + 1 + 2 * (L + 2), R + 3 * (L + 2), 1);
         push(l, 0, 0, fa[3], 16'h0, fmem(fa[3]),
              R + 1 + 3 * (L + 2), R + 4 * (L + 2), 1);
         fork
            begin
               fetch(l, fa[1]);
               fetch(l, fa[3]);
            end
            begin
               data(l, 1'b0, fa[0], 16'h0);
               data(l, 1'b1, fa[2], 16'hBEEF);
            end
         join

         // Reset during WAIT abandons the access without an ack.
         R = cyc;
         push(l, 0, 0, 16'h0040, 16'h0, 16'h0, R + 1, 0, 0);
         if_addr[l] = 16'h0040;
         if_req[l]  = 1'b1;
         step();
         step();
         rst[l] = 1'b0;
         #1;
         rst_checks(l);
         if_req[l]  = 1'b0;
         nb         = n_ack[l];
         last_dm[l] = '0;
         repeat (L + 3) step();
         chk("rst_noack", 32'(n_ack[l]), 32'(nb));
         rst[l] = 1'b1;
         step();
         R = cyc;
         push(l, 0, 0, 16'h0010, 16'h0, 16'hA5A5, R + 1, R + L + 2, 1);
         fetch(l, 16'h0010);
         drain(l);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
